dcache_nway: RTL
================

DCACHE_NWAY -- requirements
Module: dcache_nway

Parameters
REQ-001 The block SHALL have parameter WAYS, default 2, meaning associativity; legal values 1, 2, 4, 8.
REQ-002 The block SHALL have parameter SETS, default 16, meaning sets per way; power of two, at least 2.
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, meaning 64-bit words per line; power of two, at least 2.
REQ-004 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, 1 bit: CPU request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: cache can accept a request.
REQ-009 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-010 The block SHALL have port req_uncached, input, 1 bit: bypass the cache for this request.
REQ-011 The block SHALL have port req_addr, input, ADDR_W bits: byte address; bits [2:0] are ignored.
REQ-012 The block SHALL have port req_wdata, input, 64 bits: store data.
REQ-013 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port resp_rdata, output, 64 bits: load data, valid with resp_valid.
REQ-015 The block SHALL have port inval, input, 1 bit: invalidate all lines.
REQ-016 The block SHALL have port mem_req_valid, output, 1 bit: memory request present.
REQ-017 The block SHALL have port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-018 The block SHALL have port mem_req_write, output, 1 bit: memory request is a write.
REQ-019 The block SHALL have port mem_req_addr, output, ADDR_W bits: word-aligned address, bits [2:0] = 0.
REQ-020 The block SHALL have port mem_req_wdata, output, 64 bits: memory write data.
REQ-021 The block SHALL have port mem_resp_valid, input, 1 bit: memory read data present.
REQ-022 The block SHALL have port mem_resp_rdata, input, 64 bits: memory read data.

Function
REQ-023 The address SHALL split as: word offset = addr[3 +: log2(LINE_WORDS)]; index = the next log2(SETS) bits; tag = the remaining upper bits.
REQ-024 A request SHALL be accepted only in a cycle where req_valid and req_ready are both 1.
REQ-025 req_ready SHALL be 1 only in IDLE with no invalidate pending or asserted.
REQ-026 The FSM SHALL have exactly these states: IDLE, REFILL_REQ, REFILL_WAIT, MEM_WR, MEM_RD, INVAL.
REQ-027 A cacheable load hit SHALL assert resp_valid with the hit word in the cycle after acceptance; the FSM stays in IDLE, so back-to-back hits sustain one per cycle.
REQ-028 If more than one way matches, the lowest-numbered way SHALL be used.
REQ-029 A cacheable load miss SHALL go IDLE -> REFILL_REQ and fetch LINE_WORDS words starting at the line base address, in ascending order, each at the previous address + 8.
REQ-030 During refill, only one memory read SHALL be outstanding: REFILL_REQ holds mem_req_valid until mem_req_ready, then moves to REFILL_WAIT until mem_resp_valid, then returns to REFILL_REQ for the next word.
REQ-031 Each refill word SHALL be written into the victim way, where victim = the per-set round-robin pointer, or the lowest invalid way if one exists.
REQ-032 On the last refill word, the block SHALL set the tag and valid bit, advance the round-robin pointer modulo WAYS, pulse resp_valid with the requested word in the next cycle, and return to IDLE.
REQ-033 Stores SHALL be write-through and no-write-allocate: on a hit, update the cached word; in all cases go to MEM_WR and issue one memory write.
REQ-034 In MEM_WR, on the mem_req_ready handshake, the block SHALL pulse resp_valid with resp_rdata = 0 in the next cycle and return to IDLE.
REQ-035 An uncached load SHALL go to MEM_RD, perform one memory read, return mem_resp_rdata with resp_valid in the cycle after mem_resp_valid, and make no cache update.
REQ-036 An uncached store SHALL behave as a store miss: no cache update and a single memory write.
REQ-037 mem_req_valid, mem_req_addr, mem_req_write and mem_req_wdata SHALL be registered and held stable until mem_req_ready.
REQ-038 mem_resp_valid in any state other than REFILL_WAIT or MEM_RD SHALL be ignored.
REQ-039 inval asserted in IDLE SHALL cause entry to INVAL, clear all valid bits and round-robin pointers in one cycle, then return to IDLE.
REQ-040 inval asserted while not in IDLE SHALL be latched as pending and executed upon the next return to IDLE; an in-flight refill still completes and its line is then invalidated.
REQ-041 inval and req_valid asserted in the same IDLE cycle: inval SHALL win and the request SHALL NOT be accepted.

Reset
REQ-042 While reset is 1 at a clock edge: state = IDLE; all valid bits, round-robin pointers and pending invalidate cleared; resp_valid = 0, resp_rdata = 0, mem_req_valid = 0, mem_req_write = 0, mem_req_addr = 0, mem_req_wdata = 0.
REQ-043 Reset asserted mid-refill or mid-write SHALL abandon the operation, issue no resp_valid, and leave no partially filled line marked valid.
REQ-044 Data and tag arrays need not be reset.

Verification (WAYS=2, SETS=4, LINE_WORDS=4)
REQ-045 Load miss at 0x100, memory returning addr/8 per word -> reads issued at 0x100, 0x108, 0x110, 0x118; resp_rdata = 0x20.
REQ-046 Load at 0x108 right after REQ-045 -> resp_valid one cycle after acceptance with 0x21 and no memory request; back-to-back hits at 0x100, 0x110 -> 0x20, 0x22 on consecutive cycles.
REQ-047 Fill 0x000, 0x200, then 0x400 (all set 0) -> 0x400 evicts way 0 (line 0x000); a subsequent load at 0x000 misses.
REQ-048 Store 0xDEAD to 0x108 (hit) -> single memory write at 0x108; a later load at 0x108 returns 0xDEAD with no memory read; uncached load at 0x108 issues a memory read.
REQ-049 mem_req_ready held 0 for 5 cycles during refill -> address and valid stable; inval pulsed mid-refill -> refill completes and responds, then INVAL runs; a following load at 0x100 misses.
REQ-050 reset asserted in REFILL_WAIT -> next cycle: IDLE, req_ready = 1, no resp_valid; a load at the same line misses.

Source files
------------

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way set-associative write-through data cache with round-robin replacement
module dcache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_uncached,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    input  logic              inval,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [63:0]       mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_rdata
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 3 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_WAIT, MEM_WR, MEM_RD, INVAL} state_t;
    state_t state_q, state_d;

    logic [63:0]      data_q [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [WAYS][SETS];
    logic [SETS-1:0]  valid_q [WAYS];
    logic [WAY_W-1:0] rr_q [SETS];
    logic             inval_pend_q;

    logic [TAG_W-1:0] req_tag_q;
    logic [IDX_W-1:0] req_idx_q;
    logic [OFF_W-1:0] req_off_q, cnt_q;
    logic [WAY_W-1:0] victim_q;

    logic              resp_valid_q;
    logic [63:0]       resp_rdata_q;
    logic              mem_req_valid_q, mem_req_write_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic [63:0]       mem_req_wdata_q;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             unused_addr_bits;
    assign a_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign a_idx = req_addr[3+OFF_W +: IDX_W];
    assign a_off = req_addr[3 +: OFF_W];
    assign unused_addr_bits = ^req_addr[2:0];

    logic             hit, has_inv;
    logic [WAY_W-1:0] hit_way, inv_way, victim;
    logic             accept, mem_hs, refill_last;

    // Descending scan so the lowest-numbered matching / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][a_idx] && (tag_q[w][a_idx] == a_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][a_idx]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim = has_inv ? inv_way : rr_q[a_idx];
    end

    assign mem_hs      = mem_req_valid_q && mem_req_ready;
    assign refill_last = (state_q == REFILL_WAIT) && mem_resp_valid && (cnt_q == '1);

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !inval && !inval_pend_q;
                if (inval || inval_pend_q) begin
                    state_d = INVAL;
                end else if (req_valid) begin
                    accept = 1'b1;
                    if (req_write)          state_d = MEM_WR;
                    else if (req_uncached)  state_d = MEM_RD;
                    else if (!hit)          state_d = REFILL_REQ;
                end
            end
            REFILL_REQ:  if (mem_hs) state_d = REFILL_WAIT;
            REFILL_WAIT: if (mem_resp_valid) state_d = (cnt_q == '1) ? IDLE : REFILL_REQ;
            MEM_WR:      if (mem_hs) state_d = IDLE;
            MEM_RD:      if (!mem_req_valid_q && mem_resp_valid) state_d = IDLE;
            INVAL:       state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            inval_pend_q    <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            req_tag_q       <= '0;
            req_idx_q       <= '0;
            req_off_q       <= '0;
            cnt_q           <= '0;
            victim_q        <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    req_tag_q       <= a_tag;
                    req_idx_q       <= a_idx;
                    req_off_q       <= a_off;
                    victim_q        <= victim;
                    cnt_q           <= '0;
                    mem_req_write_q <= req_write;
                    mem_req_wdata_q <= req_wdata;
                    if (!req_write && !req_uncached && hit) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= data_q[hit_way][a_idx][a_off];
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= (req_write || req_uncached)
                                         ? {req_addr[ADDR_W-1:3], 3'b000}
                                         : {req_addr[ADDR_W-1:3+OFF_W], {(OFF_W+3){1'b0}}};
                    end
                    // The victim is overwritten word by word, so it must not look valid mid-refill.
                    if (!req_write && !req_uncached && !hit) valid_q[victim][a_idx] <= 1'b0;
                end
                REFILL_REQ: if (mem_hs) mem_req_valid_q <= 1'b0;
                REFILL_WAIT: if (mem_resp_valid) begin
                    if (cnt_q == req_off_q) resp_rdata_q <= mem_resp_rdata;
                    if (cnt_q == '1) begin
                        valid_q[victim_q][req_idx_q] <= 1'b1;
                        rr_q[req_idx_q] <= (rr_q[req_idx_q] == WAY_W'(WAYS - 1))
                                         ? '0 : rr_q[req_idx_q] + WAY_W'(1);
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q           <= cnt_q + OFF_W'(1);
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {req_tag_q, req_idx_q, cnt_q + OFF_W'(1), 3'b000};
                    end
                end
                MEM_WR: if (mem_hs) begin
                    mem_req_valid_q <= 1'b0;
                    mem_req_write_q <= 1'b0;
                    resp_valid_q    <= 1'b1;
                    resp_rdata_q    <= '0;
                end
                MEM_RD: begin
                    if (mem_req_valid_q) begin
                        if (mem_req_ready) mem_req_valid_q <= 1'b0;
                    end else if (mem_resp_valid) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= mem_resp_rdata;
                    end
                end
                INVAL: begin
                    for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                    for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
                    inval_pend_q <= 1'b0;
                end
                default: ;
            endcase
            if (inval && (state_q != IDLE)) inval_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept && req_write && !req_uncached && hit)
                data_q[hit_way][a_idx][a_off] <= req_wdata;
            if ((state_q == REFILL_WAIT) && mem_resp_valid)
                data_q[victim_q][req_idx_q][cnt_q] <= mem_resp_rdata;
            if (refill_last)
                tag_q[victim_q][req_idx_q] <= req_tag_q;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
endmodule
